fetch_decode_buffer: RTL and testbench

FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

---
 rtl/fetch_decode_buffer.sv | 123 ++++++++++++
 tb/tb_fetch_decode_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// Circular fetch-to-decode instruction buffer: compacts up to 4 valid slots per cycle in, presents up to 4 oldest entries out.
// One-cycle write-to-read latency. stall_o is raised when a full bundle might not fit.
module fetch_decode_buffer #(
  parameter int PKT_W = 133,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             fs2Ready_i,
  input  logic             inst0Valid_i,
  input  logic             inst1Valid_i,
  input  logic             inst2Valid_i,
  input  logic             inst3Valid_i,
  input  logic [PKT_W-1:0] inst0Packet_i,
  input  logic [PKT_W-1:0] inst1Packet_i,
  input  logic [PKT_W-1:0] inst2Packet_i,
  input  logic [PKT_W-1:0] inst3Packet_i,
  input  logic             decodeReady_i,
  output logic             out0Valid_o,
  output logic             out1Valid_o,
  output logic             out2Valid_o,
  output logic             out3Valid_o,
  output logic [PKT_W-1:0] out0Packet_o,
  output logic [PKT_W-1:0] out1Packet_o,
  output logic [PKT_W-1:0] out2Packet_o,
  output logic [PKT_W-1:0] out3Packet_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = CNT_W - 1;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0]       in_vld;
  logic [PKT_W-1:0] in_pkt  [4];
  logic [2:0]       wr_off  [4];
  logic [2:0]       enq_n, deq_n;
  logic             enq, deq;
  logic [3:0]       out_vld;
  logic [PKT_W-1:0] out_pkt [4];

  assign in_vld    = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
  assign in_pkt[0] = inst0Packet_i;
  assign in_pkt[1] = inst1Packet_i;
  assign in_pkt[2] = inst2Packet_i;
  assign in_pkt[3] = inst3Packet_i;

  // Depends only on registered count, so fetch can use it without a comb loop.
  assign stall_o = count_q > CNT_W'(DEPTH - 4);
  assign enq     = fs2Ready_i & ~stall_o & ~flush_i & ~reset;
  assign deq     = decodeReady_i & ~flush_i & ~reset;
  assign deq_n   = (count_q >= CNT_W'(4)) ? 3'd4 : count_q[2:0];

  // Each valid slot lands at tail plus the number of valid slots before it.
  always_comb begin
    enq_n  = '0;
    wr_off = '{default: '0};
    for (int k = 0; k < 4; k++) begin
      wr_off[k] = enq_n;
      enq_n     = enq_n + {2'b00, in_vld[k]};
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(enq_n);
      if (deq) head_d = head_q + PTR_W'(deq_n);
      count_d = count_q + (enq ? CNT_W'(enq_n) : '0) - (deq ? CNT_W'(deq_n) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < 4; k++) begin
        if (in_vld[k]) mem_q[tail_q + PTR_W'(wr_off[k])] <= in_pkt[k];
      end
    end
  end

  always_comb begin
    out_vld = '0;
    out_pkt = '{default: '0};
    for (int n = 0; n < 4; n++) begin
      out_vld[n] = count_q > CNT_W'(n);
      out_pkt[n] = out_vld[n] ? mem_q[head_q + PTR_W'(n)] : '0;
    end
  end

  assign out0Valid_o  = out_vld[0];
  assign out1Valid_o  = out_vld[1];
  assign out2Valid_o  = out_vld[2];
  assign out3Valid_o  = out_vld[3];
  assign out0Packet_o = out_pkt[0];
  assign out1Packet_o = out_pkt[1];
  assign out2Packet_o = out_pkt[2];
  assign out3Packet_o = out_pkt[3];
  assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: a packet queue models buffer contents and every cycle the presented group is checked.
module tb_fetch_decode_buffer;
  localparam int PKT_W = 133;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic             fs2Ready_i;
  logic             decodeReady_i;
  logic [3:0]       ivld;
  logic [PKT_W-1:0] ipkt [4];
  logic [3:0]       ovld;
  logic [PKT_W-1:0] opkt [4];
  logic             stall_o;
  logic [CNT_W-1:0] count_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [PKT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  fetch_decode_buffer #(.PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .fs2Ready_i(fs2Ready_i),
    .inst0Valid_i(ivld[0]), .inst1Valid_i(ivld[1]), .inst2Valid_i(ivld[2]), .inst3Valid_i(ivld[3]),
    .inst0Packet_i(ipkt[0]), .inst1Packet_i(ipkt[1]), .inst2Packet_i(ipkt[2]), .inst3Packet_i(ipkt[3]),
    .decodeReady_i(decodeReady_i),
    .out0Valid_o(ovld[0]), .out1Valid_o(ovld[1]), .out2Valid_o(ovld[2]), .out3Valid_o(ovld[3]),
    .out0Packet_o(opkt[0]), .out1Packet_o(opkt[1]), .out2Packet_o(opkt[2]), .out3Packet_o(opkt[3]),
    .stall_o(stall_o), .count_o(count_o)
  );

  task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PKT_W-1:0];
  endfunction

  // Check the group presented this cycle against the model, then apply this cycle's inputs to the model and clock.
  task automatic step();
    int sz;
    bit enq_ok;
    logic [PKT_W-1:0] e;
    sz = exp_q.size();
    check("count", PKT_W'(count_o), PKT_W'(sz));
    check("stall", PKT_W'(stall_o), PKT_W'(sz > DEPTH - 4));
    for (int n = 0; n < 4; n++) begin
      e = (sz > n) ? exp_q[n] : '0;
      check($sformatf("vld%0d", n), PKT_W'(ovld[n]), PKT_W'(sz > n));
      check($sformatf("pkt%0d", n), opkt[n], e);
    end
    if (reset || flush_i) begin
      exp_q.delete();
    end else begin
      enq_ok = fs2Ready_i && (sz <= DEPTH - 4);
      if (decodeReady_i) begin
        for (int n = 0; n < 4; n++) if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      if (enq_ok) begin
        for (int k = 0; k < 4; k++) if (ivld[k]) exp_q.push_back(ipkt[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // v is written inst0..inst3 left to right, e.g. 4'b1011 = slots 0,2,3 valid.
  task automatic drv(input bit fs2, input bit [3:0] v, input bit dr, input bit fl, input bit rs);
    fs2Ready_i    = fs2;
    for (int k = 0; k < 4; k++) begin
      ivld[k] = v[3-k];
      ipkt[k] = rnd_pkt();
    end
    decodeReady_i = dr;
    flush_i       = fl;
    reset         = rs;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) drv(0, 4'b0000, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; fs2Ready_i = 1'b0; decodeReady_i = 1'b0; ivld = '0;
    for (int k = 0; k < 4; k++) ipkt[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then full bundle A..D with decode stalled.
    drv(0, 4'b0000, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);
    drain();

    // Non-prefix compaction.
    drv(1, 4'b1011, 0, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);
    drain();

    // Fill to DEPTH, ignored fifth bundle, one dequeue releases stall.
    for (int i = 0; i < 4; i++) drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(0, 4'b0000, 1, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);
    drain();

    // Simultaneous enqueue and dequeue at count 6.
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1100, 0, 0, 0);
    drv(1, 4'b1100, 1, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);
    drain();

    // Pointer wrap: park head at 14, then stream 8 packets across 15 -> 0.
    drv(0, 4'b0000, 0, 0, 1);
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1100, 0, 0, 0);
    drain();
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(0, 4'b0000, 1, 0, 0);
    drv(0, 4'b0000, 1, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);

    // Flush at count 10 overriding enqueue and dequeue.
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b1100, 0, 0, 0);
    drv(1, 4'b1111, 1, 1, 0);
    drv(1, 4'b1111, 0, 0, 0);
    drv(0, 4'b0000, 0, 0, 0);

    // Reset mid-operation with enqueue and dequeue active.
    drv(1, 4'b1111, 0, 0, 0);
    drv(1, 4'b0110, 1, 0, 1);
    drv(0, 4'b0000, 0, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
          $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end
    drain();
    drv(0, 4'b0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
